pirdsp_mult_accumulator: RTL and testbench

Pipelined accumulator directly downstream of the PIRDSP 27x18 / SIMD multiplier. It registers the multiplier's two 45-bit result lanes, sums or keeps them separate according to the multiplier mode, and accumulates a burst of products into two 48-bit accumulators. When the burst ends it presents the totals through a valid/ready output port. It is the post-adder/accumulator stage of the PIRDSP slice.

---
 rtl/pirdsp_pkg.sv | 30 +++
 rtl/pirdsp_acc_lane.sv | 70 +++++++
 rtl/pirdsp_mult_accumulator.sv | 173 +++++++++++++++++
 tb/tb_pirdsp_mult_accumulator.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pirdsp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pirdsp_pkg                                                            |
// | Shared widths, multiplier mode codes and accumulator state encoding.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package pirdsp_pkg;

    localparam int ACC_W = 48;
    localparam int IN_W  = 45;

    localparam logic [1:0] MODE_27X18   = 2'b00;
    localparam logic [1:0] MODE_SUM_9X9 = 2'b01;
    localparam logic [1:0] MODE_SUM_4X4 = 2'b10;
    localparam logic [1:0] MODE_SUM_2X2 = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } acc_state_t;

    // SIMD modes keep the two lanes as independent sums.
    function automatic logic mode_is_simd(input logic [1:0] mode);
        return (mode == MODE_SUM_9X9) || (mode == MODE_SUM_4X4) ||
               (mode == MODE_SUM_2X2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pirdsp_acc_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pirdsp_acc_lane                                                       |
// | One accumulator lane: operand extension, load/accumulate, overflow.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pirdsp_acc_lane #(
    parameter int ACC_W = pirdsp_pkg::ACC_W,
    parameter int IN_W  = pirdsp_pkg::IN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic             load,
    input  logic             signed_op,
    input  logic             use_presum,
    input  logic             zero_operand,
    input  logic [IN_W-1:0]  operand,
    input  logic [ACC_W-1:0] presum,
    output logic [ACC_W-1:0] acc,
    output logic             overflow
);
    import pirdsp_pkg::*;

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_addend;
    logic [ACC_W:0]   w_sum;
    logic             w_adding;
    logic             w_ovf_signed;
    logic             w_ovf_unsigned;

    assign w_ext = signed_op ? {{(ACC_W-IN_W){operand[IN_W-1]}}, operand}
                             : {{(ACC_W-IN_W){1'b0}}, operand};

    always_comb begin
        w_addend = w_ext;
        if (zero_operand) begin
            w_addend = '0;
        end else if (use_presum) begin
            w_addend = presum;
        end
    end

    assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};
    assign w_adding = valid & ~load & ~zero_operand;

    assign w_ovf_signed   = (r_acc[ACC_W-1] == w_addend[ACC_W-1]) &&
                            (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
    assign w_ovf_unsigned = w_sum[ACC_W];

    assign overflow = w_adding & (signed_op ? w_ovf_signed : w_ovf_unsigned);

    // A forced-zero lane reloads every beat so it can never drift from 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (valid) begin
            if (load || zero_operand) begin
                r_acc <= w_addend;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
            end
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/pirdsp_mult_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pirdsp_mult_accumulator                                               |
// | Two-stage post-adder/accumulator behind the PIRDSP multiplier, with   |
// | burst control and a valid/ready result port.                          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pirdsp_mult_accumulator #(
    parameter int ACC_W = pirdsp_pkg::ACC_W,
    parameter int IN_W  = pirdsp_pkg::IN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [1:0]       mode,
    input  logic             signed_op,
    input  logic [IN_W-1:0]  result_0,
    input  logic [IN_W-1:0]  result_1,
    input  logic [15:0]      result_SIDM_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_0,
    output logic [ACC_W-1:0] acc_1,
    output logic             overflow,
    output logic [7:0]       beat_count
);
    import pirdsp_pkg::*;

    acc_state_t       r_state;
    logic             r_in_ready;
    logic [1:0]       r_mode;
    logic             r_signed;
    logic [7:0]       r_beat_count;
    logic             r_overflow;

    logic             r_s1_valid;
    logic             r_s1_first;
    logic             r_s1_last;
    logic [IN_W-1:0]  r_s1_res0;
    logic [IN_W-1:0]  r_s1_res1;
    logic [15:0]      r_unused_carry;
    logic             r_s2_last;

    logic             w_accept;
    logic             w_first;
    logic             w_out_fire;
    logic             w_mode_full;
    logic [ACC_W-1:0] w_ext0;
    logic [ACC_W-1:0] w_ext1;
    logic [ACC_W-1:0] w_presum;

    logic [IN_W-1:0]  w_lane_in  [2];
    logic [ACC_W-1:0] w_lane_acc [2];
    logic [1:0]       w_lane_ovf;

    assign w_accept   = in_valid & r_in_ready;
    assign w_first    = w_accept & (r_state == S_IDLE);
    assign w_out_fire = (r_state == S_HOLD) & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept)   r_state <= S_ACCUM;
                S_ACCUM: if (r_s2_last)  r_state <= S_HOLD;
                S_HOLD:  if (w_out_fire) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Input closes as soon as the last beat is taken, before the FSM sees it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready <= 1'b0;
        end else if (w_accept && in_last) begin
            r_in_ready <= 1'b0;
        end else if (w_out_fire || (r_state == S_IDLE)) begin
            r_in_ready <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode       <= MODE_27X18;
            r_signed     <= 1'b0;
            r_beat_count <= '0;
        end else if (w_first) begin
            r_mode       <= mode;
            r_signed     <= signed_op;
            r_beat_count <= 8'd1;
        end else if (w_accept && (r_beat_count != 8'hFF)) begin
            r_beat_count <= r_beat_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid     <= 1'b0;
            r_s1_first     <= 1'b0;
            r_s1_last      <= 1'b0;
            r_s1_res0      <= '0;
            r_s1_res1      <= '0;
            r_unused_carry <= '0;
            r_s2_last      <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_first <= w_first;
            r_s1_last  <= w_accept & in_last;
            r_s2_last  <= r_s1_valid & r_s1_last;
            if (w_accept) begin
                r_s1_res0      <= result_0;
                r_s1_res1      <= result_1;
                r_unused_carry <= result_SIDM_carry;
            end
        end
    end

    // Full-width mode folds both lanes into lane 0 before accumulation.
    assign w_mode_full = ~mode_is_simd(r_mode);
    assign w_ext0 = r_signed ? {{(ACC_W-IN_W){r_s1_res0[IN_W-1]}}, r_s1_res0}
                             : {{(ACC_W-IN_W){1'b0}}, r_s1_res0};
    assign w_ext1 = r_signed ? {{(ACC_W-IN_W){r_s1_res1[IN_W-1]}}, r_s1_res1}
                             : {{(ACC_W-IN_W){1'b0}}, r_s1_res1};
    assign w_presum = w_ext0 + w_ext1;

    assign w_lane_in[0] = r_s1_res0;
    assign w_lane_in[1] = r_s1_res1;

    genvar g;
    generate
        for (g = 0; g < 2; g = g + 1) begin : g_lane
            pirdsp_acc_lane #(
                .ACC_W (ACC_W),
                .IN_W  (IN_W)
            ) u_lane (
                .clk          (clk),
                .reset        (reset),
                .valid        (r_s1_valid),
                .load         (r_s1_first),
                .signed_op    (r_signed),
                .use_presum   ((g == 0) && w_mode_full),
                .zero_operand ((g == 1) && w_mode_full),
                .operand      (w_lane_in[g]),
                .presum       ((g == 0) ? w_presum : {ACC_W{1'b0}}),
                .acc          (w_lane_acc[g]),
                .overflow     (w_lane_ovf[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_first) begin
            r_overflow <= 1'b0;
        end else if (r_s1_valid) begin
            r_overflow <= r_overflow | (|w_lane_ovf);
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = (r_state == S_HOLD);
    assign acc_0      = w_lane_acc[0];
    assign acc_1      = w_lane_acc[1];
    assign overflow   = r_overflow;
    assign beat_count = r_beat_count;

endmodule
`default_nettype wire

// File: tb/tb_pirdsp_mult_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pirdsp_mult_accumulator                                            |
// | Scenario tasks against an integer-arithmetic burst model.             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_pirdsp_mult_accumulator;

    localparam int ACC_W = 48;
    localparam int IN_W  = 45;
    localparam int MAXB  = 300;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [1:0]       mode;
    logic             signed_op;
    logic [IN_W-1:0]  result_0;
    logic [IN_W-1:0]  result_1;
    logic [15:0]      result_SIDM_carry;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_0;
    logic [ACC_W-1:0] acc_1;
    logic             overflow;
    logic [7:0]       beat_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [IN_W-1:0] b_r0   [MAXB];
    logic [IN_W-1:0] b_r1   [MAXB];
    logic [1:0]      b_mode [MAXB];
    logic            b_sgn  [MAXB];
    int              b_n;

    pirdsp_mult_accumulator #(.ACC_W(ACC_W), .IN_W(IN_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_last           (in_last),
        .mode              (mode),
        .signed_op         (signed_op),
        .result_0          (result_0),
        .result_1          (result_1),
        .result_SIDM_carry (result_SIDM_carry),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .acc_0             (acc_0),
        .acc_1             (acc_1),
        .overflow          (overflow),
        .beat_count        (beat_count)
    );

    always #5 clk = ~clk;

    function automatic logic add_ovf(input logic [47:0] a, input logic [47:0] b, input logic sg);
        longint     s;
        logic [63:0] u;
        if (sg) begin
            s = longint'($signed(a)) + longint'($signed(b));
            return (s > 64'sd140737488355327) || (s < -64'sd140737488355328);
        end
        u = {16'b0, a} + {16'b0, b};
        return u > 64'h0000_FFFF_FFFF_FFFF;
    endfunction

    // Whole-burst expectation from the first beat's mode/sign and plain sums.
    function automatic void model_burst(output logic [47:0] e0, output logic [47:0] e1,
                                        output logic eovf, output logic [7:0] ecnt);
        logic [1:0]  m;
        logic        sg;
        longint      x0, x1;
        logic [47:0] op0, op1, a0, a1;
        m = b_mode[0];
        sg = b_sgn[0];
        a0 = '0; a1 = '0; eovf = 1'b0;
        for (int i = 0; i < b_n; i++) begin
            x0 = sg ? longint'($signed(b_r0[i])) : longint'({19'b0, b_r0[i]});
            x1 = sg ? longint'($signed(b_r1[i])) : longint'({19'b0, b_r1[i]});
            if (m == 2'b00) begin
                op0 = 48'(x0 + x1);
                op1 = '0;
            end else begin
                op0 = 48'(x0);
                op1 = 48'(x1);
            end
            if (i == 0) begin
                a0 = op0; a1 = op1;
            end else begin
                eovf = eovf | add_ovf(a0, op0, sg) | add_ovf(a1, op1, sg);
                a0 = a0 + op0;
                a1 = a1 + op1;
            end
        end
        e0 = a0; e1 = a1;
        ecnt = (b_n > 255) ? 8'hFF : 8'(b_n);
    endfunction

    // Called at a negedge; returns at the negedge after the final accept edge.
    task automatic drive_burst(input bit with_last);
        int w;
        for (int i = 0; i < b_n; i++) begin
            in_valid  = 1'b1;
            result_0  = b_r0[i];
            result_1  = b_r1[i];
            mode      = b_mode[i];
            signed_op = b_sgn[i];
            result_SIDM_carry = 16'($urandom);
            in_last   = with_last && (i == b_n - 1);
            w = 0;
            while (!in_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (w >= 100) begin
                n_checks++;
                $display("FAIL drive_timeout in_ready=%0b required=1", in_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result();
        int w;
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            n_checks++;
            $display("FAIL out_valid_timeout out_valid=%0b required=1", out_valid);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic fill_random(input int n, input logic [1:0] m, input logic sg);
        b_n = n;
        for (int i = 0; i < n; i++) begin
            b_r0[i]   = IN_W'({$urandom, $urandom});
            b_r1[i]   = IN_W'({$urandom, $urandom});
            b_mode[i] = m;
            b_sgn[i]  = sg;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        mode = 2'b00; signed_op = 1'b0; result_0 = '0; result_1 = '0;
        result_SIDM_carry = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready, overflow} !== 3'b000 || acc_0 !== '0 || acc_1 !== '0 || beat_count !== 8'd0)
            $display("FAIL reset_values ov=%0b ir=%0b of=%0b a0=%h a1=%h bc=%0d required all 0",
                     out_valid, in_ready, overflow, acc_0, acc_1, beat_count);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready got=%0b required=1", in_ready);
        else n_pass++;

        fill_random(2, 2'b01, 1'b1);
        drive_burst(1'b0);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready, overflow} !== 3'b000 || acc_0 !== '0 || acc_1 !== '0 || beat_count !== 8'd0)
            $display("FAIL midburst_reset ov=%0b ir=%0b of=%0b a0=%h a1=%h bc=%0d required all 0",
                     out_valid, in_ready, overflow, acc_0, acc_1, beat_count);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        b_n = 1; b_r0[0] = 45'd7; b_r1[0] = '0; b_mode[0] = 2'b00; b_sgn[0] = 1'b0;
        drive_burst(1'b1);
        wait_result();
        n_checks++;
        if (acc_0 !== 48'd7 || beat_count !== 8'd1)
            $display("FAIL after_reset_single a0=%0d bc=%0d required 7/1", acc_0, beat_count);
        else n_pass++;
        handshake();
    endtask

    task automatic test_mode00_signed();
        b_n = 3;
        for (int i = 0; i < 3; i++) begin
            b_r0[i] = 45'h1FFF_FFFF_FFFB;
            b_r1[i] = 45'd2;
            b_mode[i] = 2'b00;
            b_sgn[i] = 1'b1;
        end
        drive_burst(1'b1);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL lat_t1 out_valid=%0b required=0", out_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL lat_t2 out_valid=%0b required=0", out_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL lat_t3 out_valid=%0b required=1", out_valid);
        else n_pass++;
        wait_result();
        n_checks++;
        if (acc_0 !== 48'hFFFF_FFFF_FFF7 || acc_1 !== '0 || beat_count !== 8'd3 || overflow !== 1'b0)
            $display("FAIL mode00_signed a0=%h a1=%h bc=%0d of=%0b required fffffffffff7/0/3/0",
                     acc_0, acc_1, beat_count, overflow);
        else n_pass++;
        handshake();
    endtask

    task automatic test_mode01_unsigned();
        b_n = 2;
        b_r0[0] = 45'd100; b_r1[0] = 45'd1;
        b_r0[1] = 45'd200; b_r1[1] = 45'd2;
        b_mode[0] = 2'b01; b_mode[1] = 2'b01;
        b_sgn[0] = 1'b0; b_sgn[1] = 1'b0;
        drive_burst(1'b1);
        wait_result();
        n_checks++;
        if (acc_0 !== 48'd300 || acc_1 !== 48'd3 || beat_count !== 8'd2)
            $display("FAIL mode01_unsigned a0=%0d a1=%0d bc=%0d required 300/3/2", acc_0, acc_1, beat_count);
        else n_pass++;
        handshake();
    endtask

    task automatic test_backpressure();
        logic [47:0] ea0, ea1, eb0, eb1;
        logic        eaov, ebov;
        logic [7:0]  eac, ebc;
        fill_random(3, 2'b01, 1'b0);
        model_burst(ea0, ea1, eaov, eac);
        drive_burst(1'b1);
        wait_result();
        fill_random(4, 2'b10, 1'b1);
        model_burst(eb0, eb1, ebov, ebc);
        in_valid = 1'b1; in_last = 1'b0;
        result_0 = b_r0[0]; result_1 = b_r1[0]; mode = b_mode[0]; signed_op = b_sgn[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || acc_0 !== ea0 || acc_1 !== ea1 ||
                beat_count !== eac || overflow !== eaov)
                $display("FAIL hold_stable c=%0d ir=%0b ov=%0b a0=%h a1=%h bc=%0d required ir=0 ov=1 a0=%h a1=%h bc=%0d",
                         c, in_ready, out_valid, acc_0, acc_1, beat_count, ea0, ea1, eac);
            else n_pass++;
        end
        handshake();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL post_handshake ir=%0b ov=%0b required 1/0", in_ready, out_valid);
        else n_pass++;
        drive_burst(1'b1);
        wait_result();
        n_checks++;
        if (acc_0 !== eb0 || acc_1 !== eb1 || beat_count !== ebc || overflow !== ebov)
            $display("FAIL second_burst a0=%h a1=%h bc=%0d of=%0b required %h/%h/%0d/%0b",
                     acc_0, acc_1, beat_count, overflow, eb0, eb1, ebc, ebov);
        else n_pass++;
        handshake();
    endtask

    task automatic test_overflow();
        logic [47:0] exp0;
        b_n = 9;
        for (int i = 0; i < 9; i++) begin
            b_r0[i] = 45'h0FFF_FFFF_FFFF;
            b_r1[i] = '0;
            b_mode[i] = 2'b10;
            b_sgn[i] = 1'b1;
        end
        exp0 = 48'(64'd9 * 64'h0000_0FFF_FFFF_FFFF);
        drive_burst(1'b1);
        wait_result();
        n_checks++;
        if (overflow !== 1'b1 || acc_0 !== exp0 || acc_1 !== '0 || beat_count !== 8'd9)
            $display("FAIL overflow of=%0b a0=%h a1=%h bc=%0d required 1/%h/0/9",
                     overflow, acc_0, acc_1, beat_count, exp0);
        else n_pass++;
        handshake();
    endtask

    task automatic test_mode_latch();
        logic [47:0] e0, e1;
        logic        eov;
        logic [7:0]  ec;
        fill_random(3, 2'b01, 1'b0);
        b_mode[1] = 2'b00; b_sgn[1] = 1'b1;
        b_mode[2] = 2'b00; b_sgn[2] = 1'b1;
        model_burst(e0, e1, eov, ec);
        drive_burst(1'b1);
        wait_result();
        n_checks++;
        if (acc_0 !== e0 || acc_1 !== e1 || overflow !== eov || beat_count !== ec)
            $display("FAIL mode_latch a0=%h a1=%h of=%0b bc=%0d required %h/%h/%0b/%0d",
                     acc_0, acc_1, overflow, beat_count, e0, e1, eov, ec);
        else n_pass++;
        handshake();
        fill_random(1, 2'b11, 1'b1);
        model_burst(e0, e1, eov, ec);
        drive_burst(1'b1);
        wait_result();
        n_checks++;
        if (acc_0 !== e0 || acc_1 !== e1 || overflow !== 1'b0 || beat_count !== 8'd1)
            $display("FAIL single_beat a0=%h a1=%h of=%0b bc=%0d required %h/%h/0/1",
                     acc_0, acc_1, overflow, beat_count, e0, e1);
        else n_pass++;
        handshake();
    endtask

    task automatic test_saturation();
        logic [47:0] e0, e1;
        logic        eov;
        logic [7:0]  ec;
        b_n = 260;
        for (int i = 0; i < 260; i++) begin
            b_r0[i] = IN_W'($urandom_range(1000));
            b_r1[i] = IN_W'($urandom_range(1000));
            b_mode[i] = 2'b01;
            b_sgn[i] = 1'b0;
        end
        model_burst(e0, e1, eov, ec);
        drive_burst(1'b1);
        wait_result();
        n_checks++;
        if (beat_count !== 8'hFF || acc_0 !== e0 || acc_1 !== e1 || overflow !== eov)
            $display("FAIL saturation bc=%0d a0=%h a1=%h of=%0b required 255/%h/%h/%0b",
                     beat_count, acc_0, acc_1, overflow, e0, e1, eov);
        else n_pass++;
        handshake();
    endtask

    task automatic test_random_bursts();
        logic [47:0] e0, e1;
        logic        eov;
        logic [7:0]  ec;
        for (int k = 0; k < 8; k++) begin
            fill_random(int'($urandom_range(8, 1)), 2'($urandom), 1'($urandom));
            model_burst(e0, e1, eov, ec);
            drive_burst(1'b1);
            wait_result();
            n_checks++;
            if (acc_0 !== e0 || acc_1 !== e1 || overflow !== eov || beat_count !== ec)
                $display("FAIL random_burst k=%0d m=%0d a0=%h a1=%h of=%0b bc=%0d required %h/%h/%0b/%0d",
                         k, b_mode[0], acc_0, acc_1, overflow, beat_count, e0, e1, eov, ec);
            else n_pass++;
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_mode00_signed();
        test_mode01_unsigned();
        test_backpressure();
        test_overflow();
        test_mode_latch();
        test_saturation();
        test_random_bursts();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout time=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
